uart_tx_fifo: RTL and testbench

Buffered UART transmitter. Host bytes are pushed into an internal FIFO, and a serializer drains them as 8-bit frames on uart_txd. Each frame is start bit, 8 data bits LSB first, optional parity, then one stop bit. The block sits on the transmit side of the UART link, opposite UART_RX, and lets the host burst-write without polling busy per byte.

---
 rtl/uart_tx_fifo.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO absorbs host bytes and a serializer drains
// them as start / 8 data (LSB first) / optional parity / stop frames on uart_txd.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk_50M,
    input  logic                          rst_n,
    input  logic                          write_en,
    input  logic [7:0]                    write_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          uart_txd,
    output logic                          busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic              PARITY_ON = (PARITY_EN != 0);
    localparam logic              ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [7:0]       head;

    assign full       = (count == CNT_FULL);
    assign empty      = (count == '0);
    assign fifo_count = count;
    assign head       = mem[rd_ptr];

    // A full FIFO refuses the push even when the serializer pops in the same cycle.
    assign push = write_en && !full;

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= write_en && full;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone decide
    // which entries are valid, so clearing the data would only cost logic.
    always_ff @(posedge clk_50M) begin
        if (push) mem[wr_ptr] <= write_data;
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_next;
    logic [7:0]        shift;
    logic [7:0]        shift_next;
    logic              parity_bit;
    logic              parity_next;
    logic              txd_next;
    logic              bit_done;

    assign bit_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            uart_txd   <= 1'b1;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_idx    <= bit_next;
            shift      <= shift_next;
            parity_bit <= parity_next;
            uart_txd   <= txd_next;
        end
    end

    // NOTE: every signal driven here gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        bit_next    = bit_idx;
        shift_next  = shift;
        parity_next = parity_bit;
        pop         = 1'b0;
        baud_next   = (state == IDLE || bit_done) ? '0 : baud_cnt + BAUD_W'(1);

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) state_next = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_next = {1'b0, shift[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = PARITY_ON ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_done) state_next = STOP;
            end
            STOP: begin
                // Back-to-back frames: the next byte starts with no idle gap.
                if (bit_done) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (pop) begin
            shift_next  = head;
            bit_next    = '0;
            baud_next   = '0;
            parity_next = (^head) ^ ODD_BIT;
        end

        // The line register is loaded with the level of the state being entered.
        case (state_next)
            IDLE:    txd_next = 1'b1;
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
            PARITY:  txd_next = parity_next;
            STOP:    txd_next = 1'b1;
            default: txd_next = 1'b1;
        endcase
    end

    assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a line monitor decodes frames and compares them with
// a scoreboard of accepted bytes; scenario tasks check flags and timing inline.
module tb_uart_tx_fifo;

    localparam int CPB   = 10;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       write_en;
    logic [7:0] write_data;
    logic       full, empty, overflow, txd, busy;
    logic [4:0] fifo_count;

    logic       p_write_en;
    logic [7:0] p_write_data;
    logic       pe_full, pe_empty, pe_overflow, pe_txd, pe_busy;
    logic [4:0] pe_count;
    logic       po_full, po_empty, po_overflow, po_txd, po_busy;
    logic [4:0] po_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int rx_count     = 0;
    bit mon_discard  = 1'b0;
    logic [7:0] sb[$];
    int start_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH),
                   .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk_50M(clk), .rst_n(rst_n), .write_en(write_en), .write_data(write_data),
        .full(full), .empty(empty), .fifo_count(fifo_count), .overflow(overflow),
        .uart_txd(txd), .busy(busy));

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH),
                   .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
        .clk_50M(clk), .rst_n(rst_n), .write_en(p_write_en), .write_data(p_write_data),
        .full(pe_full), .empty(pe_empty), .fifo_count(pe_count), .overflow(pe_overflow),
        .uart_txd(pe_txd), .busy(pe_busy));

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH),
                   .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
        .clk_50M(clk), .rst_n(rst_n), .write_en(p_write_en), .write_data(p_write_data),
        .full(po_full), .empty(po_empty), .fifo_count(po_count), .overflow(po_overflow),
        .uart_txd(po_txd), .busy(po_busy));

    // Line monitor on the non-parity instance, sampling mid-bit on falling edges.
    initial begin : monitor
        int         st;
        logic [7:0] b;
        logic [7:0] exp_b;
        logic       start_ok;
        logic       stop_b;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                st = cyc;
                repeat (CPB / 2 - 1) @(negedge clk);
                start_ok = (txd === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                stop_b = txd;
                if (mon_discard) begin
                    mon_discard = 1'b0;
                end else begin
                    rx_count++;
                    start_cyc.push_back(st);
                    tests_run++;
                    if (!start_ok || stop_b !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL frame_format: start_ok=%0b stop=%0b, required start_ok=1 stop=1",
                                 start_ok, stop_b);
                    end
                    tests_run++;
                    if (sb.size() == 0) begin
                        tests_failed++;
                        $display("FAIL rx_unexpected: got byte %02h, required no frame", b);
                    end else begin
                        exp_b = sb.pop_front();
                        if (b !== exp_b) begin
                            tests_failed++;
                            $display("FAIL rx_byte: got %02h, required %02h", b, exp_b);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy || pe_busy || po_busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
        end
        repeat (2) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; write_en = 1'b0; write_data = '0;
        p_write_en = 1'b0; p_write_data = '0;
        step(); step();
        tests_run++; if (txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd: got %0b, required 1", txd); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %0b, required 0", full); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %0b, required 1", empty); end
        tests_run++; if (fifo_count !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %0b, required 0", overflow); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [9:0] fr;
        fr = {1'b1, 8'h55, 1'b0};
        write_en = 1'b1; write_data = 8'h55; sb.push_back(8'h55);
        step();
        write_en = 1'b0;
        tests_run++; if (fifo_count !== 5'd1 || empty !== 1'b0) begin tests_failed++;
            $display("FAIL single_push: count=%0d empty=%0b, required count=1 empty=0", fifo_count, empty); end
        step();
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL single_pop: empty=%0b, required 1", empty); end
        for (int k = 0; k < 10 * CPB; k++) begin
            tests_run++; if (txd !== fr[k / CPB]) begin tests_failed++;
                $display("FAIL single_wave: cycle %0d txd=%0b, required %0b", k, txd, fr[k / CPB]); end
            tests_run++; if (busy !== 1'b1) begin tests_failed++;
                $display("FAIL single_busy: cycle %0d busy=%0b, required 1", k, busy); end
            step();
        end
        tests_run++; if (busy !== 1'b0 || txd !== 1'b1) begin tests_failed++;
            $display("FAIL single_end: busy=%0b txd=%0b, required busy=0 txd=1", busy, txd); end
        wait_idle(50, "single_idle");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int first, rx0, peak;
        bytes[0] = 8'h01; bytes[1] = 8'h33; bytes[2] = 8'hCF;
        first = start_cyc.size(); rx0 = rx_count; peak = 0;
        for (int i = 0; i < 3; i++) begin
            write_en = 1'b1; write_data = bytes[i]; sb.push_back(bytes[i]);
            step();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        write_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        tests_run++; if (peak != 2) begin tests_failed++; $display("FAIL b2b_peak: got %0d, required 2", peak); end
        wait_idle(40 * CPB, "b2b_idle");
        tests_run++; if (rx_count - rx0 != 3) begin tests_failed++;
            $display("FAIL b2b_frames: got %0d, required 3", rx_count - rx0); end
        if (start_cyc.size() >= first + 3) begin
            for (int i = 1; i < 3; i++) begin
                tests_run++; if (start_cyc[first + i] - start_cyc[first + i - 1] != 10 * CPB) begin tests_failed++;
                    $display("FAIL b2b_gap: spacing %0d, required %0d",
                             start_cyc[first + i] - start_cyc[first + i - 1], 10 * CPB); end
            end
        end else begin
            tests_run++; tests_failed++;
            $display("FAIL b2b_starts: got %0d frame starts, required 3", start_cyc.size() - first);
        end
    endtask

    task automatic test_overflow();
        int rx0, ovf;
        rx0 = rx_count; ovf = 0;
        write_en = 1'b1; write_data = 8'hA0; sb.push_back(8'hA0);
        step();
        write_en = 1'b0;
        step();
        for (int i = 0; i < 18; i++) begin
            write_en = 1'b1; write_data = 8'(8'h80 + i);
            if (i < DEPTH) sb.push_back(8'(8'h80 + i));
            step();
            if (overflow) ovf++;
            if (i == DEPTH - 2) begin
                tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL ovf_not_full: got %0b, required 0", full); end
            end
            if (i == DEPTH - 1) begin
                tests_run++; if (full !== 1'b1 || fifo_count !== 5'd16) begin tests_failed++;
                    $display("FAIL ovf_full: full=%0b count=%0d, required full=1 count=16", full, fifo_count); end
            end
        end
        write_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (overflow) ovf++;
        end
        tests_run++; if (ovf != 2) begin tests_failed++; $display("FAIL ovf_pulses: got %0d, required 2", ovf); end
        wait_idle(20 * 10 * CPB, "ovf_idle");
        tests_run++; if (rx_count - rx0 != 17) begin tests_failed++;
            $display("FAIL ovf_frames: got %0d, required 17", rx_count - rx0); end
    endtask

    task automatic test_parity();
        logic [10:0] fe, fo;
        fe = {1'b1, 1'b1, 8'h07, 1'b0};
        fo = {1'b1, 1'b0, 8'h07, 1'b0};
        p_write_en = 1'b1; p_write_data = 8'h07;
        step();
        p_write_en = 1'b0;
        step();
        for (int k = 0; k < 11 * CPB; k++) begin
            if (k % CPB == CPB / 2) begin
                tests_run++; if (pe_txd !== fe[k / CPB]) begin tests_failed++;
                    $display("FAIL parity_even_bit%0d: got %0b, required %0b", k / CPB, pe_txd, fe[k / CPB]); end
                tests_run++; if (po_txd !== fo[k / CPB]) begin tests_failed++;
                    $display("FAIL parity_odd_bit%0d: got %0b, required %0b", k / CPB, po_txd, fo[k / CPB]); end
            end
            if (k == 11 * CPB - 1) begin
                tests_run++; if (pe_busy !== 1'b1) begin tests_failed++;
                    $display("FAIL parity_len_last: busy=%0b, required 1", pe_busy); end
            end
            step();
        end
        tests_run++; if (pe_busy !== 1'b0 || po_busy !== 1'b0) begin tests_failed++;
            $display("FAIL parity_len_end: even busy=%0b odd busy=%0b, required 0 0", pe_busy, po_busy); end
        wait_idle(50, "parity_idle");
    endtask

    task automatic test_reset_abort();
        int rx0, lows;
        for (int i = 0; i < 5; i++) begin
            write_en = 1'b1; write_data = 8'(8'hB0 + i); sb.push_back(8'(8'hB0 + i));
            step();
        end
        write_en = 1'b0;
        tests_run++; if (fifo_count !== 5'd4) begin tests_failed++;
            $display("FAIL abort_queued: got %0d, required 4", fifo_count); end
        repeat (3 * CPB) step();
        sb.delete();
        mon_discard = 1'b1;
        rx0 = rx_count;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests_run++; if (txd !== 1'b1) begin tests_failed++; $display("FAIL abort_txd: got %0b, required 1", txd); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL abort_empty: got %0b, required 1", empty); end
        tests_run++; if (fifo_count !== 5'd0) begin tests_failed++; $display("FAIL abort_count: got %0d, required 0", fifo_count); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %0b, required 0", busy); end
        lows = 0;
        for (int i = 0; i < 60 * CPB; i++) begin
            step();
            if (txd !== 1'b1) lows++;
        end
        tests_run++; if (lows != 0) begin tests_failed++; $display("FAIL abort_line: %0d low cycles, required 0", lows); end
        tests_run++; if (rx_count != rx0) begin tests_failed++;
            $display("FAIL abort_frames: got %0d frames, required 0", rx_count - rx0); end
    endtask

    task automatic test_full_pop_collision();
        int rx0, n, waited, guard;
        rx0 = rx_count;
        write_en = 1'b1; write_data = 8'hC0; sb.push_back(8'hC0);
        step();
        write_en = 1'b0;
        step();
        for (n = 0; n < DEPTH; n++) begin
            write_en = 1'b1; write_data = 8'(n); sb.push_back(8'(n));
            step();
        end
        tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL coll_full: got %0b, required 1", full); end
        // Keep pushing into the full FIFO until the serializer's pop lands.
        write_data = 8'hEE;
        waited = 0;
        while (fifo_count == 5'd16 && waited < 20 * CPB) begin
            step();
            waited++;
        end
        write_en = 1'b0;
        tests_run++; if (fifo_count !== 5'd15) begin tests_failed++;
            $display("FAIL coll_count: got %0d after %0d cycles, required 15", fifo_count, waited); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++;
            $display("FAIL coll_overflow: got %0b, required 1", overflow); end
        guard = 0;
        while (n < 40 && guard < 60 * 10 * CPB) begin
            if (fifo_count < 5'd16) begin
                write_en = 1'b1; write_data = 8'(n); sb.push_back(8'(n));
                n++;
            end else begin
                write_en = 1'b0;
            end
            step();
            guard++;
        end
        write_en = 1'b0;
        tests_run++; if (n != 40) begin tests_failed++; $display("FAIL coll_pushed: got %0d, required 40", n); end
        wait_idle(45 * 10 * CPB, "coll_idle");
        tests_run++; if (rx_count - rx0 != 41) begin tests_failed++;
            $display("FAIL coll_frames: got %0d, required 41", rx_count - rx0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_parity();
        test_reset_abort();
        test_full_pop_collision();
        tests_run++; if (sb.size() != 0) begin tests_failed++;
            $display("FAIL sb_drained: %0d bytes outstanding, required 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
